// File: rtl/snake_pkg.sv
// Shared constants and types for the snake movement block.
// Direction codes, coordinate width, FSM state type, start position.
package snake_pkg;

    localparam int COORD_W = 8;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_CHECK,
        ST_MOVE,
        ST_DEAD
    } state_t;

    // Head starts at (START_X, START_Y); body trails to the left.
    localparam logic [COORD_W-1:0] START_X   = 8'd2;
    localparam logic [COORD_W-1:0] START_Y   = 8'd0;
    localparam logic [15:0]        START_LEN = 16'd3;

    function automatic logic [15:0] seg_xy(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator for one step in direction dir.
// Ports: head_x/head_y in, dir in, new_x/new_y out, out_of_field out.
// SNAKE_WRAP_EN defined: edges wrap around, out_of_field stays 0.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int SIZE_X = 10,
    parameter int SIZE_Y = 10
) (
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  logic [1:0]         dir,
    output logic [COORD_W-1:0] new_x,
    output logic [COORD_W-1:0] new_y,
    output logic               out_of_field
);

    localparam logic [COORD_W-1:0] MAX_X = COORD_W'(SIZE_X - 1);
    localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(SIZE_Y - 1);

    always_comb begin
        new_x        = head_x;
        new_y        = head_y;
        out_of_field = 1'b0;
        unique case (dir)
            DIR_UP: begin
                if (head_y == '0) begin
`ifdef SNAKE_WRAP_EN
                    new_y = MAX_Y;
`else
                    out_of_field = 1'b1;
`endif
                end else begin
                    new_y = head_y - 8'd1;
                end
            end
            DIR_RIGHT: begin
                if (head_x == MAX_X) begin
`ifdef SNAKE_WRAP_EN
                    new_x = '0;
`else
                    out_of_field = 1'b1;
`endif
                end else begin
                    new_x = head_x + 8'd1;
                end
            end
            DIR_DOWN: begin
                if (head_y == MAX_Y) begin
`ifdef SNAKE_WRAP_EN
                    new_y = '0;
`else
                    out_of_field = 1'b1;
`endif
                end else begin
                    new_y = head_y + 8'd1;
                end
            end
            default: begin
                if (head_x == '0) begin
`ifdef SNAKE_WRAP_EN
                    new_x = MAX_X;
`else
                    out_of_field = 1'b1;
`endif
                end else begin
                    new_x = head_x - 8'd1;
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_move.sv
// Snake body owner: advances the snake one cell per step request.
// Ports: clk, rst (sync, active-high), step, dir/dir_valid, grow in;
// snake_xy, length, moved, busy, game_over out.
// SNAKE_WRAP_EN (in snake_next_head) turns walls into wrap-around.
module snake_move
    import snake_pkg::*;
#(
    parameter int SIZE_X     = 10,
    parameter int SIZE_Y     = 10,
    parameter int MAX_LEN    = SIZE_X * SIZE_Y,
    parameter int SNAKE_SIZE = 16 * MAX_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    input  logic [1:0]            dir,
    input  logic                  dir_valid,
    input  logic                  grow,
    output logic [SNAKE_SIZE-1:0] snake_xy,
    output logic [15:0]           length,
    output logic                  moved,
    output logic                  busy,
    output logic                  game_over
);

    localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

    state_t               state;
    logic [1:0]           cur_dir;
    logic [1:0]           pend_dir;
    logic                 grow_pending;
    logic                 grow_applied;
    logic [COORD_W-1:0]   nh_x;
    logic [COORD_W-1:0]   nh_y;
    logic [15:0]          n_cnt;
    logic [15:0]          idx;
    logic [15:0]          seg_idx;
    logic [COORD_W-1:0]   calc_x;
    logic [COORD_W-1:0]   calc_y;
    logic                 calc_oof;
    logic                 dir_ok;
    logic                 grow_now;

    snake_next_head #(
        .SIZE_X(SIZE_X),
        .SIZE_Y(SIZE_Y)
    ) u_next_head (
        .head_x      (snake_xy[7:0]),
        .head_y      (snake_xy[15:8]),
        .dir         (pend_dir),
        .new_x       (calc_x),
        .new_y       (calc_y),
        .out_of_field(calc_oof)
    );

    // A request equal to the current direction flipped is a reversal.
    assign dir_ok   = dir_valid && (dir != (cur_dir ^ 2'b10));
    assign grow_now = grow_pending && (length < MAX_LEN16);

    always_comb begin
        seg_idx = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx == 16'(i)) begin
                seg_idx = snake_xy[16*i +: 16];
            end
        end
    end

    // moved keeps busy up through the pulse cycle after MOVE.
    assign busy = (state == ST_HEAD) || (state == ST_CHECK) ||
                  (state == ST_MOVE) || moved;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cur_dir      <= DIR_RIGHT;
            pend_dir     <= DIR_RIGHT;
            grow_pending <= 1'b0;
            grow_applied <= 1'b0;
            nh_x         <= '0;
            nh_y         <= '0;
            n_cnt        <= '0;
            idx          <= '0;
            length       <= START_LEN;
            moved        <= 1'b0;
            game_over    <= 1'b0;
            snake_xy     <= '0;
            snake_xy[47:0] <= {
                seg_xy(START_X - 8'd2, START_Y),
                seg_xy(START_X - 8'd1, START_Y),
                seg_xy(START_X, START_Y)
            };
        end else begin
            moved <= 1'b0;
            if (state != ST_DEAD) begin
                if (dir_ok) begin
                    pend_dir <= dir;
                end
                if (grow) begin
                    grow_pending <= 1'b1;
                end
            end
            unique case (state)
                ST_IDLE: begin
                    if (step) begin
                        state <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (calc_oof) begin
                        state <= ST_DEAD;
                    end else begin
                        nh_x         <= calc_x;
                        nh_y         <= calc_y;
                        grow_applied <= grow_now;
                        n_cnt        <= grow_now ? length
                                                 : length - 16'd1;
                        idx          <= '0;
                        state        <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (seg_idx == {nh_y, nh_x}) begin
                        state <= ST_DEAD;
                    end else if (idx == n_cnt - 16'd1) begin
                        state <= ST_MOVE;
                    end else begin
                        idx <= idx + 16'd1;
                    end
                end
                ST_MOVE: begin
                    snake_xy <= {snake_xy[SNAKE_SIZE-17:0], nh_y, nh_x};
                    cur_dir  <= pend_dir;
                    if (grow_applied) begin
                        length       <= length + 16'd1;
                        // A grow arriving now survives for the next step.
                        grow_pending <= grow;
                    end
                    moved <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_DEAD: begin
                    game_over <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_move.sv
// Directed bench for snake_move on a 10x10 field.
// Table of step vectors plus hand sequences for the corner cases.
module tb_snake_move;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          step = 1'b0;
    logic [1:0]    dir = 2'b00;
    logic          dir_valid = 1'b0;
    logic          grow = 1'b0;
    logic [1599:0] snake_xy;
    logic [15:0]   length;
    logic          moved;
    logic          busy;
    logic          game_over;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    snake_move dut (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .dir      (dir),
        .dir_valid(dir_valid),
        .grow     (grow),
        .snake_xy (snake_xy),
        .length   (length),
        .moved    (moved),
        .busy     (busy),
        .game_over(game_over)
    );

    typedef struct {
        bit         dv;
        logic [1:0] d;
        bit         g;
        logic [7:0] hx;
        logic [7:0] hy;
        int         len;
        logic [7:0] tx;
        logic [7:0] ty;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] seg(input int i);
        return snake_xy[16*i +: 16];
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pre(input bit dv, input logic [1:0] d, input bit g);
        if (dv || g) begin
            dir_valid = dv;
            dir       = d;
            grow      = g;
            tick();
            dir_valid = 1'b0;
            grow      = 1'b0;
        end
    endtask

    task automatic do_step(output int lat, output bit busy_seen);
        step = 1'b1;
        tick();
        step = 1'b0;
        busy_seen = busy;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (moved) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic step_dead(input string name);
        bit saw_moved;
        bit got_go;
        step = 1'b1;
        tick();
        step = 1'b0;
        saw_moved = 1'b0;
        got_go = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (moved) saw_moved = 1'b1;
            if (game_over) begin
                got_go = 1'b1;
                break;
            end
        end
        chk({name, "_game_over"}, 64'(got_go), 64'd1);
        chk({name, "_no_moved"}, 64'(saw_moved), 64'd0);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_len"}, 64'(length), 64'd3);
        chk({name, "_body"}, snake_xy[63:0], 64'h0000_0000_0001_0002);
        chk({name, "_upper"}, 64'(|(snake_xy >> 64)), 64'd0);
        chk({name, "_moved"}, 64'(moved), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_game_over"}, 64'(game_over), 64'd0);
    endtask

    initial begin
        int lat;
        bit bs;

        vecs[0] = '{0, 2'b00, 0, 3, 0, 3, 1, 0, 4};
        vecs[1] = '{0, 2'b00, 0, 4, 0, 3, 2, 0, 4};
        vecs[2] = '{0, 2'b00, 0, 5, 0, 3, 3, 0, 4};
        vecs[3] = '{1, 2'b11, 0, 6, 0, 3, 4, 0, 4};
        vecs[4] = '{0, 2'b00, 1, 7, 0, 4, 4, 0, 5};
        vecs[5] = '{1, 2'b10, 0, 7, 1, 4, 5, 0, 5};
        vecs[6] = '{1, 2'b11, 0, 6, 1, 4, 6, 0, 5};
        vecs[7] = '{1, 2'b10, 0, 6, 2, 4, 7, 0, 5};
        vecs[8] = '{1, 2'b01, 0, 7, 2, 4, 7, 1, 5};

        do_reset();
        check_reset("reset");

        for (int v = 0; v < 9; v++) begin
            pre(vecs[v].dv, vecs[v].d, vecs[v].g);
            do_step(lat, bs);
            chk($sformatf("v%0d_lat", v), 64'(lat), 64'(vecs[v].lat));
            chk($sformatf("v%0d_busy", v), 64'(bs), 64'd1);
            chk($sformatf("v%0d_head", v), 64'(seg(0)),
                64'({vecs[v].hy, vecs[v].hx}));
            chk($sformatf("v%0d_len", v), 64'(length), 64'(vecs[v].len));
            chk($sformatf("v%0d_tail", v), 64'(seg(vecs[v].len - 1)),
                64'({vecs[v].ty, vecs[v].tx}));
            tick();
            chk($sformatf("v%0d_pulse", v), 64'(moved), 64'd0);
        end

        // Reversal straight after reset is ignored.
        do_reset();
        pre(1, 2'b11, 0);
        do_step(lat, bs);
        chk("rev_head", 64'(seg(0)), 64'h0003);
        chk("rev_lat", 64'(lat), 64'd4);

        // Grow from reset keeps tail at origin.
        do_reset();
        pre(0, 2'b00, 1);
        do_step(lat, bs);
        chk("grow_lat", 64'(lat), 64'd5);
        chk("grow_len", 64'(length), 64'd4);
        chk("grow_tail", 64'(seg(3)), 64'h0000);
        chk("grow_head", 64'(seg(0)), 64'h0003);

        // Length 5, then down, left, up into own body.
        pre(0, 2'b00, 1);
        do_step(lat, bs);
        chk("self_len5", 64'(length), 64'd5);
        chk("self_lat6", 64'(lat), 64'd6);
        pre(1, 2'b10, 0);
        do_step(lat, bs);
        chk("self_down", 64'(seg(0)), 64'h0104);
        pre(1, 2'b11, 0);
        do_step(lat, bs);
        chk("self_left", 64'(seg(0)), 64'h0103);
        pre(1, 2'b00, 0);
        step_dead("self");
        chk("self_head_kept", 64'(seg(0)), 64'h0103);
        chk("self_len_kept", 64'(length), 64'd5);
        step = 1'b1;
        tick();
        step = 1'b0;
        bs = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (moved) bs = 1'b1;
        end
        chk("dead_step_ignored", 64'(bs), 64'd0);
        chk("dead_sticky", 64'(game_over), 64'd1);
        do_reset();
        check_reset("dead_reset");
        do_step(lat, bs);
        chk("post_reset_head", 64'(seg(0)), 64'h0003);

`ifdef SNAKE_WRAP_EN
        do_reset();
        pre(1, 2'b10, 0);
        do_step(lat, bs);
        pre(1, 2'b11, 0);
        do_step(lat, bs);
        do_step(lat, bs);
        chk("wrap_pre", 64'(seg(0)), 64'h0100);
        pre(1, 2'b00, 0);
        do_step(lat, bs);
        chk("wrap_origin", 64'(seg(0)), 64'h0000);
        do_step(lat, bs);
        chk("wrap_lat", 64'(lat), 64'd4);
        chk("wrap_head", 64'(seg(0)), 64'h0900);
        chk("wrap_game_over", 64'(game_over), 64'd0);
`else
        do_reset();
        for (int s = 0; s < 7; s++) begin
            do_step(lat, bs);
        end
        chk("wall_pre", 64'(seg(0)), 64'h0009);
        chk("wall_pre_lat", 64'(lat), 64'd4);
        step_dead("wall");
        chk("wall_head_kept", 64'(seg(0)), 64'h0009);
        chk("wall_len_kept", 64'(length), 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_move.md
# snake_move

Owns the snake body and advances it one cell per game step. It holds the packed segment coordinate array and the current length, applies direction requests and growth requests, and detects wall and self collisions. Its `snake_xy`, `length` and `moved` outputs feed the field-calculation stage directly: `moved` drives that stage's `step`.

## Interface
- `SIZE_X`, default 10, field width in cells (≥3, ≤256)
- `SIZE_Y`, default 10, field height in cells (≥1, ≤256)
- `MAX_LEN`, default `SIZE_X*SIZE_Y`, maximum segment count
- `SNAKE_SIZE`, default `16*MAX_LEN`, width of `snake_xy`
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `step` in 1: single-cycle game tick request
- `dir` in 2: requested direction; 00 up (y−1), 01 right (x+1), 10 down (y+1), 11 left (x−1)
- `dir_valid` in 1: `dir` is valid this cycle
- `grow` in 1: apple-eaten pulse; the next move lengthens the snake by one
- `snake_xy` out `SNAKE_SIZE`: segment i has x at [16i+7:16i] and y at [16i+15:16i+8]; segment 0 is the head
- `length` out 16: number of valid segments
- `moved` out 1: one-cycle pulse when `snake_xy`/`length` have just been updated
- `busy` out 1: high while a step is being processed
- `game_over` out 1: sticky collision flag

## Operation
- Reset values:
  - length = 3; segments 0..2 = (2,0), (1,0), (0,0); all other segments = 0.
  - Current direction = right; pending direction = right; grow_pending = 0.
  - `moved` = 0, `busy` = 0, `game_over` = 0; FSM in IDLE.
- Direction handling:
  - A `dir_valid` in any state loads the pending direction, unless `dir` equals current direction XOR 2'b10 (a reversal), which is ignored.
  - If several direction requests arrive before a move, the last accepted one wins.
  - Current direction takes the pending value in MOVE.
- Growth: `grow` sets grow_pending in any state. It is cleared in MOVE when consumed. Requests coinciding with MOVE carry over to the next step.
- FSM states IDLE, HEAD, CHECK, MOVE, DEAD:
  - IDLE: `step`=1 → HEAD. Otherwise stay.
  - HEAD: compute the new head from segment 0 and the pending direction.
    - Leaving the field → DEAD.
    - Else latch new head, set N = length if grow_pending and length < MAX_LEN, else N = length−1 (tail vacates), idx = 0 → CHECK.
  - CHECK: compare segment idx with the new head, one segment per cycle.
    - Match → DEAD.
    - idx = N−1 without a match → MOVE.
  - MOVE: shift segments i ← i−1 for i = 1..MAX_LEN−1 and write the new head into segment 0.
    - If grow was applied, length+1 (saturates at MAX_LEN; at MAX_LEN, grow_pending stays set).
    - Pulse `moved`, then return to IDLE.
  - DEAD: `game_over`=1. `step`, `dir`, `grow` are ignored. Only `rst` exits.
- `step` while not in IDLE is dropped (not queued).
- In DEAD, `snake_xy`/`length` keep their last moved values.
- `rst` in any state, mid-operation included, restores reset values on the next edge.
- Coordinate arithmetic uses 8-bit unsigned values. Wall tests are x=0 moving left, x=SIZE_X−1 moving right, y=0 moving up, y=SIZE_Y−1 moving down.

## Timing
- Step sampled at edge t: HEAD at t+1, CHECK for N cycles, MOVE at the next edge.
- `moved` is high for exactly one cycle, starting N+2 cycles after `step` was sampled. `snake_xy` and `length` are stable from that cycle on.
- `busy` is high from the cycle after `step` is sampled through the cycle in which `moved` is high.
- `game_over` rises one cycle after the colliding HEAD or CHECK edge. `moved` does not pulse on a collision.
- `snake_xy`, `length`, `moved`, `game_over` are all registered outputs.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - Leaving an edge wraps to the opposite edge (x=SIZE_X−1 right → 0, x=0 left → SIZE_X−1, same for y).
  - Only self collision ends the game.
- `SNAKE_WRAP_EN` undefined: edges are walls as described above.

## Structure
- Shared package `snake_pkg` holds:
  - direction encoding constants DIR_UP/RIGHT/DOWN/LEFT
  - COORD_W = 8
  - the FSM state typedef
  - reset start position constants
- Sub-module `snake_next_head` is combinational. It takes head x/y and direction and returns new x/y plus an `out_of_field` flag; the `SNAKE_WRAP_EN` logic lives there.

## Test plan
- Reset, then 3 `step` pulses with no `dir` → head (5,0), length 3, `moved` pulses 4 cycles after each step (N=2).
- After reset, `dir`=11 (left) then `step` → reversal ignored, head (3,0).
- Without `SNAKE_WRAP_EN`, SIZE_X=10, step right until head (9,0), one more step → `game_over`=1, no `moved`, head stays (9,0).
- `grow` pulse then `step` → length 4, tail remains (0,0), `moved` 5 cycles after step.
- Length 5; steps down, left, up → self collision detected in CHECK, `game_over`=1. Then `rst` mid-DEAD → reset values restored.
- With `SNAKE_WRAP_EN`, head (0,0) heading up, `step` → head (0,SIZE_Y−1), `game_over`=0.
